// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: NUM_REGS x REG_W configuration registers on the fx byte bus.
// Multi-byte writes are assembled in a shadow and committed atomically, with a
// one-cycle cfg_upd pulse per register. Reads return one byte with one cycle
// of latency.
// Optional macro CFG_SNAPSHOT_EN: a lane-0 read captures the whole register so
// later lanes of the same register read back coherently.
//
// Handshake: fx_wr / fx_rd are single-cycle strobes with no back-pressure.
// A strobe is consumed on the rising clk_sys edge where it is high. fx_q is
// valid from the edge after fx_rd and holds until the next fx_rd.
module cfg_reg_bank #(
  parameter int              NUM_REGS = 16,
  parameter int              REG_W    = 32,
  parameter logic [REG_W-1:0] RST_VAL = '0
) (
  input  logic                      clk_sys,
  input  logic                      rst_n,
  input  logic [5:0]                dev_id,
  input  logic                      fx_wr,
  input  logic [21:0]               fx_waddr,
  input  logic [7:0]                fx_data,
  input  logic                      fx_rd,
  input  logic [21:0]               fx_raddr,
  output logic [7:0]                fx_q,
  output logic [NUM_REGS*REG_W-1:0] cfg_q,
  output logic [NUM_REGS-1:0]       cfg_upd,
  output logic                      cfg_err
);

  localparam int BYTES = REG_W / 8;
  localparam int LB    = (BYTES == 4) ? 2 : (BYTES == 2) ? 1 : 0;
  localparam int IW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  // fsm_state is the observable write-FSM state
  state_t state_q, state_d, fsm_state;
  assign fsm_state = state_q;

  logic [REG_W-1:0]    regs [NUM_REGS];
  logic [REG_W-1:0]    shadow_q;
  logic [REG_W-1:0]    commit_val;
  logic [IW-1:0]       cur_idx_q;
  logic [1:0]          exp_lane_q;
  logic [NUM_REGS-1:0] upd_q;
  logic                err_q;

  // Write address decode; lane uses only the low LB bits, idx the rest
  logic [15:0]   widx;
  logic [1:0]    wlane;
  logic [IW-1:0] wsel;
  logic          wvalid;
  assign widx   = fx_waddr[15:0] >> LB;
  assign wlane  = fx_waddr[1:0] & 2'(BYTES - 1);
  assign wsel   = widx[IW-1:0];
  assign wvalid = fx_wr && (fx_waddr[21:16] == dev_id) && (widx < 16'(NUM_REGS));

  // Read address decode
  logic [15:0]   ridx;
  logic [1:0]    rlane;
  logic [IW-1:0] rsel;
  logic          rvalid;
  assign ridx   = fx_raddr[15:0] >> LB;
  assign rlane  = fx_raddr[1:0] & 2'(BYTES - 1);
  assign rsel   = ridx[IW-1:0];
  assign rvalid = (fx_raddr[21:16] == dev_id) && (ridx < 16'(NUM_REGS));

  logic do_start, do_store, do_commit, do_err;

  // Write FSM state register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Write FSM next state and datapath controls
  always_comb begin
    state_d   = state_q;
    do_start  = 1'b0;
    do_store  = 1'b0;
    do_commit = 1'b0;
    do_err    = 1'b0;
    if (wvalid) begin
      case (state_q)
        IDLE: begin
          if (wlane != 2'd0) begin
            do_err = 1'b1;
          end else if (BYTES == 1) begin
            do_commit = 1'b1;
          end else begin
            do_start = 1'b1;
            state_d  = COLLECT;
          end
        end
        COLLECT: begin
          if ((wsel == cur_idx_q) && (wlane == exp_lane_q)) begin
            if (wlane == 2'(BYTES - 1)) begin
              do_commit = 1'b1;
              state_d   = IDLE;
            end else begin
              do_store = 1'b1;
            end
          end else begin
            do_err = 1'b1;
            if (wlane == 2'd0) begin
              do_start = 1'b1;
              state_d  = COLLECT;
            end else begin
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The committing byte is always the top lane; lower lanes come from shadow
  always_comb begin
    commit_val = shadow_q;
    commit_val[REG_W-1 -: 8] = fx_data;
  end

  // Shadow assembly, register commit, update pulse and sticky error
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
      shadow_q   <= '0;
      cur_idx_q  <= '0;
      exp_lane_q <= '0;
      upd_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      upd_q <= '0;
      if (do_err) err_q <= 1'b1;
      if (do_start) begin
        shadow_q[7:0] <= fx_data;
        cur_idx_q     <= wsel;
        exp_lane_q    <= 2'd1;
      end
      if (do_store) begin
        for (int b = 0; b < BYTES; b++)
          if (wlane == 2'(b)) shadow_q[b*8 +: 8] <= fx_data;
        exp_lane_q <= exp_lane_q + 2'd1;
      end
      if (do_commit) begin
        regs[wsel]  <= commit_val;
        upd_q[wsel] <= 1'b1;
      end
    end
  end

`ifdef CFG_SNAPSHOT_EN
  logic [REG_W-1:0] snap_q;
  logic [IW-1:0]    snap_idx_q;
`endif

  // Byte selected for a non-zero lane read: snapshot when it covers this idx
  logic [REG_W-1:0] rd_src;
  logic [7:0]       rd_byte;
  always_comb begin
    rd_src = regs[rsel];
`ifdef CFG_SNAPSHOT_EN
    if (rsel == snap_idx_q) rd_src = snap_q;
`endif
    rd_byte = rd_src[7:0];
    for (int b = 0; b < BYTES; b++)
      if (rlane == 2'(b)) rd_byte = rd_src[b*8 +: 8];
  end

  // Registered read data and, when enabled, the lane-0 snapshot
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fx_q <= 8'h00;
`ifdef CFG_SNAPSHOT_EN
      snap_q     <= '0;
      snap_idx_q <= '0;
`endif
    end else if (fx_rd) begin
      if (!rvalid) begin
        fx_q <= 8'h00;
      end else if (rlane == 2'd0) begin
        fx_q <= regs[rsel][7:0];
`ifdef CFG_SNAPSHOT_EN
        snap_q     <= regs[rsel];
        snap_idx_q <= rsel;
`endif
      end else begin
        fx_q <= rd_byte;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign cfg_q[i*REG_W +: REG_W] = regs[i];
  end

  assign cfg_upd = upd_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Directed bench for cfg_reg_bank (default parameters: 16 x 32-bit, reset 0).
// A table of single-cycle vectors covers decode, assembly, errors and reads;
// hand-written sequences cover the snapshot and the mid-assembly reset.
module tb_cfg_reg_bank;

  localparam int NR = 16;
  localparam int RW = 32;
  localparam logic [5:0] D5 = 6'h05;
  localparam logic [5:0] D6 = 6'h06;

  logic             clk_sys = 1'b0;
  logic             rst_n   = 1'b0;
  logic [5:0]       dev_id  = D5;
  logic             fx_wr   = 1'b0;
  logic [21:0]      fx_waddr = '0;
  logic [7:0]       fx_data  = '0;
  logic             fx_rd   = 1'b0;
  logic [21:0]      fx_raddr = '0;
  logic [7:0]       fx_q;
  logic [NR*RW-1:0] cfg_q;
  logic [NR-1:0]    cfg_upd;
  logic             cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  cfg_reg_bank #(.NUM_REGS(NR), .REG_W(RW), .RST_VAL('0)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .dev_id(dev_id),
    .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
    .cfg_q(cfg_q), .cfg_upd(cfg_upd), .cfg_err(cfg_err)
  );

  // Clock and watchdog
  always #5 clk_sys = ~clk_sys;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [21:0] wa;
    logic [7:0]  d;
    logic        rd;
    logic [21:0] ra;
    logic        chk_q;
    logic [7:0]  exp_q;
    int          ri;
    logic [31:0] exp_reg;
    logic [15:0] exp_upd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [21:0] ad(input logic [5:0] dv, input int idx, input int lane);
    return {dv, 16'(idx * 4 + lane)};
  endfunction

  function automatic logic [31:0] reg_of(input int i);
    return cfg_q[i*RW +: RW];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Drive one cycle of strobes; returns #1 after the consuming edge
  task automatic step(input logic wr, input logic [21:0] wa, input logic [7:0] d,
                      input logic rd, input logic [21:0] ra);
    @(negedge clk_sys);
    fx_wr = wr; fx_waddr = wa; fx_data = d; fx_rd = rd; fx_raddr = ra;
    @(posedge clk_sys);
    #1;
    fx_wr = 1'b0; fx_rd = 1'b0;
  endtask

  task automatic wr_b(input logic [5:0] dv, input int idx, input int lane, input logic [7:0] d);
    step(1'b1, ad(dv, idx, lane), d, 1'b0, '0);
  endtask

  task automatic rd_b(input logic [5:0] dv, input int idx, input int lane);
    step(1'b0, '0, 8'h00, 1'b1, ad(dv, idx, lane));
  endtask

  task automatic add(input logic wr, input logic [21:0] wa, input logic [7:0] d,
                     input logic rd, input logic [21:0] ra, input logic chk_q,
                     input logic [7:0] exp_q, input int ri, input logic [31:0] exp_reg,
                     input logic [15:0] exp_upd, input logic exp_err);
    vec_t v;
    v.wr = wr; v.wa = wa; v.d = d; v.rd = rd; v.ra = ra; v.chk_q = chk_q;
    v.exp_q = exp_q; v.ri = ri; v.exp_reg = exp_reg; v.exp_upd = exp_upd;
    v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic vw(input logic [5:0] dv, input int idx, input int lane, input logic [7:0] d,
                    input int ri, input logic [31:0] r, input logic [15:0] u, input logic e);
    add(1'b1, ad(dv, idx, lane), d, 1'b0, '0, 1'b0, 8'h00, ri, r, u, e);
  endtask

  task automatic vr(input logic [5:0] dv, input int idx, input int lane, input logic [7:0] q,
                    input int ri, input logic [31:0] r, input logic e);
    add(1'b0, '0, 8'h00, 1'b1, ad(dv, idx, lane), 1'b1, q, ri, r, 16'h0000, e);
  endtask

  task automatic vi(input int ri, input logic [31:0] r, input logic [15:0] u, input logic e,
                    input logic cq, input logic [7:0] q);
    add(1'b0, '0, 8'h00, 1'b0, '0, cq, q, ri, r, u, e);
  endtask

  logic [7:0] exp_l1, exp_l2, exp_l3;

  initial begin
    // Reset reads of reg 3
    for (int l = 0; l < 4; l++) vr(D5, 3, l, 8'h00, 3, 32'h0, 1'b0);
    // Atomic assembly of reg 2
    vw(D5, 2, 0, 8'h11, 2, 32'h0, 16'h0, 1'b0);
    vw(D5, 2, 1, 8'h22, 2, 32'h0, 16'h0, 1'b0);
    vw(D5, 2, 2, 8'h33, 2, 32'h0, 16'h0, 1'b0);
    vw(D5, 2, 3, 8'h44, 2, 32'h44332211, 16'h0004, 1'b0);
    vi(2, 32'h44332211, 16'h0, 1'b0, 1'b0, 8'h00);
    vr(D5, 2, 0, 8'h11, 2, 32'h44332211, 1'b0);
    vr(D5, 2, 1, 8'h22, 2, 32'h44332211, 1'b0);
    vr(D5, 2, 2, 8'h33, 2, 32'h44332211, 1'b0);
    vr(D5, 2, 3, 8'h44, 2, 32'h44332211, 1'b0);
    vi(2, 32'h44332211, 16'h0, 1'b0, 1'b1, 8'h44);
    // Ignored accesses: foreign device and idx out of range
    vw(D6, 2, 3, 8'hEE, 2, 32'h44332211, 16'h0, 1'b0);
    for (int l = 0; l < 4; l++)
      vw(D6, 2, l, 8'hF0 + 8'(l), 2, 32'h44332211, 16'h0, 1'b0);
    vw(D5, 16, 3, 8'hE1, 0, 32'h0, 16'h0, 1'b0);
    vw(D5, 16, 0, 8'hE2, 0, 32'h0, 16'h0, 1'b0);
    vw(D5, 16, 3, 8'hE3, 0, 32'h0, 16'h0, 1'b0);
    vr(D5, 2, 1, 8'h22, 2, 32'h44332211, 1'b0);
    vr(D5, 16, 0, 8'h00, 2, 32'h44332211, 1'b0);
    vr(D5, 2, 2, 8'h33, 2, 32'h44332211, 1'b0);
    vr(D6, 2, 0, 8'h00, 2, 32'h44332211, 1'b0);
    // Same-cycle read of lane 0 and final-byte commit returns old data
    vw(D5, 2, 0, 8'h91, 2, 32'h44332211, 16'h0, 1'b0);
    vw(D5, 2, 1, 8'h92, 2, 32'h44332211, 16'h0, 1'b0);
    vw(D5, 2, 2, 8'h93, 2, 32'h44332211, 16'h0, 1'b0);
    add(1'b1, ad(D5, 2, 3), 8'h94, 1'b1, ad(D5, 2, 0), 1'b1, 8'h11,
        2, 32'h94939291, 16'h0004, 1'b0);
    // Out-of-order lane sets the sticky error, then a clean write of reg 1
    vw(D5, 1, 0, 8'h55, 1, 32'h0, 16'h0, 1'b0);
    vw(D5, 1, 2, 8'h66, 1, 32'h0, 16'h0, 1'b1);
    vi(1, 32'h0, 16'h0, 1'b1, 1'b0, 8'h00);
    vw(D5, 1, 0, 8'hA1, 1, 32'h0, 16'h0, 1'b1);
    vw(D5, 1, 1, 8'hA2, 1, 32'h0, 16'h0, 1'b1);
    vw(D5, 1, 2, 8'hA3, 1, 32'h0, 16'h0, 1'b1);
    vw(D5, 1, 3, 8'hA4, 1, 32'hA4A3A2A1, 16'h0002, 1'b1);
    // Lane 0 of another register mid-assembly restarts on the new idx
    vw(D5, 4, 0, 8'h01, 4, 32'h0, 16'h0, 1'b1);
    vw(D5, 4, 1, 8'h02, 4, 32'h0, 16'h0, 1'b1);
    vw(D5, 6, 0, 8'h10, 4, 32'h0, 16'h0, 1'b1);
    vw(D5, 6, 1, 8'h20, 6, 32'h0, 16'h0, 1'b1);
    vw(D5, 6, 2, 8'h30, 6, 32'h0, 16'h0, 1'b1);
    vw(D5, 6, 3, 8'h40, 6, 32'h40302010, 16'h0040, 1'b1);
    vi(4, 32'h0, 16'h0, 1'b1, 1'b0, 8'h00);

    // Reset block
    rst_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    #1;
    chk("rst_upd", 32'(cfg_upd), 32'h0);
    chk("rst_err", 32'(cfg_err), 32'h0);
    chk("rst_q", 32'(fx_q), 32'h0);
    chk("rst_cfg_any", 32'(|cfg_q), 32'h0);

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      step(v.wr, v.wa, v.d, v.rd, v.ra);
      if (v.chk_q) chk($sformatf("v%0d_fx_q", i), 32'(fx_q), 32'(v.exp_q));
      chk($sformatf("v%0d_reg%0d", i, v.ri), reg_of(v.ri), v.exp_reg);
      chk($sformatf("v%0d_upd", i), 32'(cfg_upd), 32'(v.exp_upd));
      chk($sformatf("v%0d_err", i), 32'(cfg_err), 32'(v.exp_err));
    end

    // Snapshot coherence across a commit between lane reads
`ifdef CFG_SNAPSHOT_EN
    exp_l1 = 8'hCC; exp_l2 = 8'hBB; exp_l3 = 8'hAA;
`else
    exp_l1 = 8'h03; exp_l2 = 8'h02; exp_l3 = 8'h01;
`endif
    wr_b(D5, 0, 0, 8'hDD); wr_b(D5, 0, 1, 8'hCC);
    wr_b(D5, 0, 2, 8'hBB); wr_b(D5, 0, 3, 8'hAA);
    chk("snap_reg0_a", reg_of(0), 32'hAABBCCDD);
    rd_b(D5, 0, 0);
    chk("snap_l0", 32'(fx_q), 32'h000000DD);
    wr_b(D5, 0, 0, 8'h04); wr_b(D5, 0, 1, 8'h03);
    wr_b(D5, 0, 2, 8'h02); wr_b(D5, 0, 3, 8'h01);
    chk("snap_reg0_b", reg_of(0), 32'h01020304);
    rd_b(D5, 0, 1);
    chk("snap_l1", 32'(fx_q), 32'(exp_l1));
    rd_b(D5, 0, 2);
    chk("snap_l2", 32'(fx_q), 32'(exp_l2));
    rd_b(D5, 0, 3);
    chk("snap_l3", 32'(fx_q), 32'(exp_l3));

    // Reset in the middle of assembling reg 5
    wr_b(D5, 5, 0, 8'h12); wr_b(D5, 5, 1, 8'h34);
    @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cfg_any", 32'(|cfg_q), 32'h0);
    chk("mid_rst_err", 32'(cfg_err), 32'h0);
    chk("mid_rst_q", 32'(fx_q), 32'h0);
    chk("mid_rst_upd", 32'(cfg_upd), 32'h0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    wr_b(D5, 5, 2, 8'h56);
    chk("post_rst_l2_err", 32'(cfg_err), 32'h1);
    chk("post_rst_l2_reg5", reg_of(5), 32'h0);
    wr_b(D5, 5, 3, 8'h78);
    chk("post_rst_l3_err", 32'(cfg_err), 32'h1);
    chk("post_rst_l3_reg5", reg_of(5), 32'h0);
    chk("post_rst_l3_upd", 32'(cfg_upd), 32'h0);
    wr_b(D5, 5, 0, 8'hC1); wr_b(D5, 5, 1, 8'hC2); wr_b(D5, 5, 2, 8'hC3);
    chk("post_rst_part_reg5", reg_of(5), 32'h0);
    wr_b(D5, 5, 3, 8'hC4);
    chk("post_rst_reg5", reg_of(5), 32'hC4C3C2C1);
    chk("post_rst_upd", 32'(cfg_upd), 32'h0020);
    step(1'b0, '0, 8'h00, 1'b0, '0);
    chk("post_rst_upd_clr", 32'(cfg_upd), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
